// File: rtl/alu_pkg.sv
// ============================================================================
// Package  : alu_pkg
// Purpose  : Opcodes of the 4-bit ALU, the wide-operation codes and the
//            sequencer state type shared by the wide sequencer and its users.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        OP_SEL       = 4'd0,
        OP_INC       = 4'd1,
        OP_DEC       = 4'd2,
        OP_ADD       = 4'd3,
        OP_ADD_C     = 4'd4,
        OP_SUB       = 4'd5,
        OP_SUB_B     = 4'd6,
        OP_AND       = 4'd7,
        OP_OR        = 4'd8,
        OP_XOR       = 4'd9,
        OP_NOT       = 4'd10,
        OP_SHL       = 4'd11,
        OP_SHR       = 4'd12,
        OP_INVALID_0 = 4'd13,
        OP_INVALID_1 = 4'd14,
        OP_INVALID_2 = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        W_ADD = 3'd0,
        W_SUB = 3'd1,
        W_AND = 3'd2,
        W_OR  = 3'd3,
        W_XOR = 3'd4
    } wop_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    function automatic logic wop_is_valid(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    // Only the arithmetic ops seed the chain with the requester's carry-in.
    function automatic logic wop_chains_carry(input wop_e op);
        return (op == W_ADD) || (op == W_SUB);
    endfunction

    function automatic opcode_e wop_to_opcode(input wop_e op);
        opcode_e code;
        case (op)
            W_ADD:   code = OP_ADD_C;
            W_SUB:   code = OP_SUB_B;
            W_AND:   code = OP_AND;
            W_OR:    code = OP_OR;
            W_XOR:   code = OP_XOR;
            default: code = OP_SEL;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wide_seq_if.sv
// ============================================================================
// Interface : alu_wide_seq_if
// Purpose   : Requester handshake, response and 4-bit ALU port bundle of the
//             wide sequencer.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_wide_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int c_WIDTH = 4 * NIBBLES;

    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [c_WIDTH-1:0] req_a;
    logic [c_WIDTH-1:0] req_b;
    logic               req_cin;

    logic               rsp_valid;
    logic [c_WIDTH-1:0] rsp_result;
    logic               rsp_carry;
    logic               rsp_zero;
    logic               rsp_err;

    logic               alu_valid_in;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic               alu_cin;
    logic [3:0]         alu_ctl;
    logic               alu_valid_out;
    logic [3:0]         alu_result;
    logic               alu_carry;
    logic               alu_zero;

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin,
        output req_ready,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
        output alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
        input  alu_valid_out, alu_result, alu_carry, alu_zero
    );

    // Requester plus ALU side.
    modport master (
        output req_valid, req_op, req_a, req_b, req_cin,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
        input  alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
        output alu_valid_out, alu_result, alu_carry, alu_zero
    );

endinterface

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// ============================================================================
// Module   : alu_wide_seq
// Purpose  : Executes 4*NIBBLES-bit add/sub/logic ops as a chain of 4-bit ALU
//            transactions, carrying through a local carry register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_wide_seq_if.slave bus
);

    localparam int                 c_WIDTH = 4 * NIBBLES;
    localparam int                 c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NIBBLES - 1);

    seq_state_e         r_state,          w_state_nxt;
    logic [c_WIDTH-1:0] r_a,              w_a_nxt;
    logic [c_WIDTH-1:0] r_b,              w_b_nxt;
    wop_e               r_op,             w_op_nxt;
    logic               r_carry,          w_carry_nxt;
    logic [c_IDX_W-1:0] r_idx,            w_idx_nxt;
    logic [c_WIDTH-1:0] r_result,         w_result_nxt;
    logic               r_alu_valid_in,   w_alu_valid_in_nxt;
    logic [3:0]         r_alu_a,          w_alu_a_nxt;
    logic [3:0]         r_alu_b,          w_alu_b_nxt;
    logic               r_alu_cin,        w_alu_cin_nxt;
    opcode_e            r_alu_ctl,        w_alu_ctl_nxt;
    logic               r_rsp_valid,      w_rsp_valid_nxt;
    logic [c_WIDTH-1:0] r_rsp_result,     w_rsp_result_nxt;
    logic               r_rsp_carry,      w_rsp_carry_nxt;
    logic               r_rsp_zero,       w_rsp_zero_nxt;
    logic               r_rsp_err,        w_rsp_err_nxt;

    logic [c_WIDTH-1:0] w_cap_result;
    logic [c_IDX_W-1:0] w_idx_inc;
    logic               w_start_carry;
    logic               unused_alu_zero;

    // Zero is evaluated over the full width, so the per-nibble flag is not needed.
    assign unused_alu_zero = bus.alu_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= W_ADD;
            r_carry        <= 1'b0;
            r_idx          <= '0;
            r_result       <= '0;
            r_alu_valid_in <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_cin      <= 1'b0;
            r_alu_ctl      <= OP_SEL;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_a            <= w_a_nxt;
            r_b            <= w_b_nxt;
            r_op           <= w_op_nxt;
            r_carry        <= w_carry_nxt;
            r_idx          <= w_idx_nxt;
            r_result       <= w_result_nxt;
            r_alu_valid_in <= w_alu_valid_in_nxt;
            r_alu_a        <= w_alu_a_nxt;
            r_alu_b        <= w_alu_b_nxt;
            r_alu_cin      <= w_alu_cin_nxt;
            r_alu_ctl      <= w_alu_ctl_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_result   <= w_rsp_result_nxt;
            r_rsp_carry    <= w_rsp_carry_nxt;
            r_rsp_zero     <= w_rsp_zero_nxt;
            r_rsp_err      <= w_rsp_err_nxt;
        end
    end

    // Outputs are registered on entry to the state that owns them, so the ALU
    // strobe is high during ISSUE and the response pulse is high during DONE.
    always_comb begin
        w_state_nxt        = r_state;
        w_a_nxt            = r_a;
        w_b_nxt            = r_b;
        w_op_nxt           = r_op;
        w_carry_nxt        = r_carry;
        w_idx_nxt          = r_idx;
        w_result_nxt       = r_result;
        w_alu_valid_in_nxt = 1'b0;
        w_alu_a_nxt        = r_alu_a;
        w_alu_b_nxt        = r_alu_b;
        w_alu_cin_nxt      = r_alu_cin;
        w_alu_ctl_nxt      = r_alu_ctl;
        w_rsp_valid_nxt    = 1'b0;
        w_rsp_result_nxt   = r_rsp_result;
        w_rsp_carry_nxt    = r_rsp_carry;
        w_rsp_zero_nxt     = r_rsp_zero;
        w_rsp_err_nxt      = r_rsp_err;

        w_cap_result                       = r_result;
        w_cap_result[{r_idx, 2'b00} +: 4]  = bus.alu_result;
        w_idx_inc                          = r_idx + c_IDX_W'(1);
        w_start_carry                      = wop_chains_carry(wop_e'(bus.req_op)) & bus.req_cin;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_a_nxt      = bus.req_a;
                    w_b_nxt      = bus.req_b;
                    w_op_nxt     = wop_e'(bus.req_op);
                    w_idx_nxt    = '0;
                    w_result_nxt = '0;
                    if (wop_is_valid(bus.req_op)) begin
                        w_carry_nxt        = w_start_carry;
                        w_alu_valid_in_nxt = 1'b1;
                        w_alu_a_nxt        = bus.req_a[3:0];
                        w_alu_b_nxt        = bus.req_b[3:0];
                        w_alu_cin_nxt      = w_start_carry;
                        w_alu_ctl_nxt      = wop_to_opcode(wop_e'(bus.req_op));
                        w_state_nxt        = S_ISSUE;
                    end else begin
                        w_carry_nxt      = 1'b0;
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_result_nxt = '0;
                        w_rsp_carry_nxt  = 1'b0;
                        w_rsp_zero_nxt   = 1'b1;
                        w_rsp_err_nxt    = 1'b1;
                        w_state_nxt      = S_DONE;
                    end
                end
            end

            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (bus.alu_valid_out) begin
                    w_result_nxt = w_cap_result;
                    w_carry_nxt  = bus.alu_carry;
                    if (r_idx == c_LAST) begin
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_result_nxt = w_cap_result;
                        w_rsp_carry_nxt  = bus.alu_carry;
                        w_rsp_zero_nxt   = (w_cap_result == '0);
                        w_rsp_err_nxt    = 1'b0;
                        w_state_nxt      = S_DONE;
                    end else begin
                        w_idx_nxt          = w_idx_inc;
                        w_alu_valid_in_nxt = 1'b1;
                        w_alu_a_nxt        = r_a[{w_idx_inc, 2'b00} +: 4];
                        w_alu_b_nxt        = r_b[{w_idx_inc, 2'b00} +: 4];
                        w_alu_cin_nxt      = bus.alu_carry;
                        w_alu_ctl_nxt      = wop_to_opcode(r_op);
                        w_state_nxt        = S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.alu_valid_in = r_alu_valid_in;
    assign bus.alu_a        = r_alu_a;
    assign bus.alu_b        = r_alu_b;
    assign bus.alu_cin      = r_alu_cin;
    assign bus.alu_ctl      = r_alu_ctl;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_carry    = r_rsp_carry;
    assign bus.rsp_zero     = r_rsp_zero;
    assign bus.rsp_err      = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
// ============================================================================
// Module   : tb_alu_wide_seq
// Purpose  : Self-checking bench for alu_wide_seq with a behavioural 4-bit ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_wide_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk;
    logic reset;

    alu_wide_seq_if #(.NIBBLES(N)) bus ();

    alu_wide_seq #(.NIBBLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stall control is written only by the stimulus process.
    int stall_amt        = 0;
    bit stall_first_only = 1'b0;
    int issue_base       = 0;

    // ALU transaction log is written only by the ALU model.
    int         n_issue = 0;
    logic [3:0] log_ctl [1024];
    logic       log_cin [1024];
    logic [3:0] log_a   [1024];
    logic [3:0] log_b   [1024];
    logic [4:0] pend;
    int         pend_cnt;

    function automatic logic [4:0] alu_calc(input logic [3:0] ctl, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
        case (ctl)
            4'd4:    return {1'b0, a} + {1'b0, b} + {4'd0, cin};
            4'd6:    return {1'b0, a} - {1'b0, b} - {4'd0, cin};
            4'd7:    return {1'b0, a & b};
            4'd8:    return {1'b0, a | b};
            4'd9:    return {1'b0, a ^ b};
            default: return 5'd0;
        endcase
    endfunction

    // Registered 4-bit ALU: one cycle latency plus an optional stall.
    always @(posedge clk or negedge reset) begin : alu_model
        logic [4:0] r5;
        int         s;
        if (!reset) begin
            bus.alu_valid_out <= 1'b0;
            bus.alu_result    <= 4'd0;
            bus.alu_carry     <= 1'b0;
            bus.alu_zero      <= 1'b0;
            pend_cnt          <= 0;
        end else begin
            bus.alu_valid_out <= 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) begin
                    bus.alu_valid_out <= 1'b1;
                    bus.alu_result    <= pend[3:0];
                    bus.alu_carry     <= pend[4];
                    bus.alu_zero      <= (pend[3:0] == 4'd0);
                end
            end
            if (bus.alu_valid_in) begin
                r5 = alu_calc(bus.alu_ctl, bus.alu_a, bus.alu_b, bus.alu_cin);
                log_ctl[n_issue % 1024] <= bus.alu_ctl;
                log_cin[n_issue % 1024] <= bus.alu_cin;
                log_a[n_issue % 1024]   <= bus.alu_a;
                log_b[n_issue % 1024]   <= bus.alu_b;
                n_issue                 <= n_issue + 1;
                s = (stall_first_only && (n_issue != issue_base)) ? 0 : stall_amt;
                if (s == 0) begin
                    bus.alu_valid_out <= 1'b1;
                    bus.alu_result    <= r5[3:0];
                    bus.alu_carry     <= r5[4];
                    bus.alu_zero      <= (r5[3:0] == 4'd0);
                end else begin
                    pend     <= r5;
                    pend_cnt <= s;
                end
            end
        end
    end

    // Reference: full-width arithmetic, returns {err, carry, result}.
    function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        case (op)
            3'd0: begin t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; return {1'b0, t}; end
            3'd1: begin t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin}; return {1'b0, t}; end
            3'd2: return {2'b00, a & b};
            3'd3: return {2'b00, a | b};
            3'd4: return {2'b00, a ^ b};
            default: return {1'b1, 1'b0, {W{1'b0}}};
        endcase
    endfunction

    // Carry/borrow entering nibble k is what the lower 4k bits produce on their own.
    function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cin, input int k);
        longint mask, ua, ub, t;
        if (op > 3'd1) return 1'b0;
        mask = (64'sd1 <<< (4 * k)) - 64'sd1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        if (op == 3'd0) begin
            t = ua + ub + longint'(cin);
            return ((t >>> (4 * k)) & 64'sd1) != 64'sd0;
        end
        t = ua - ub - longint'(cin);
        return t < 0;
    endfunction

    function automatic logic [3:0] exp_ctl(input logic [2:0] op);
        case (op)
            3'd0:    return 4'd4;
            3'd1:    return 4'd6;
            3'd2:    return 4'd7;
            3'd3:    return 4'd8;
            3'd4:    return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_and_check(input string tag, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic [W-1:0] exp_res,
                                   input logic exp_c, input logic exp_z, input logic exp_e,
                                   input int exp_lat);
        int base;
        int edges;
        int n_iss;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        edges = 0;
        while (!bus.req_ready && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        base       = n_issue;
        issue_base = base;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
        bus.req_op    = 3'($urandom);
        edges = 0;
        while (!bus.rsp_valid && edges < 200) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " result"},    32'(bus.rsp_result), 32'(exp_res));
        check({tag, " carry"},     32'(bus.rsp_carry), 32'(exp_c));
        check({tag, " zero"},      32'(bus.rsp_zero), 32'(exp_z));
        check({tag, " err"},       32'(bus.rsp_err), 32'(exp_e));
        check({tag, " latency"},   32'(edges + 1), 32'(exp_lat));
        n_iss = n_issue - base;
        check({tag, " issues"},    32'(n_iss), exp_e ? 32'd0 : 32'(N));
        for (int k = 0; k < N && k < n_iss; k++) begin
            check($sformatf("%s ctl%0d", tag, k), 32'(log_ctl[(base + k) % 1024]), 32'(exp_ctl(op)));
            check($sformatf("%s cin%0d", tag, k), 32'(log_cin[(base + k) % 1024]),
                  32'(exp_cin(op, a, b, cin, k)));
            check($sformatf("%s a%0d", tag, k),   32'(log_a[(base + k) % 1024]), 32'(a[4*k +: 4]));
            check($sformatf("%s b%0d", tag, k),   32'(log_b[(base + k) % 1024]), 32'(b[4*k +: 4]));
        end
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [W+1:0] r;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         cin;
        int           s;
        int           first_rsp, second_rsp, ready_edge, n_rsp, rsp_seen;
        logic [W-1:0] res1, res2;

        vecs[0] = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9};
        vecs[1] = '{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 9};
        vecs[2] = '{3'd1, 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 9};
        vecs[3] = '{3'd4, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9};
        vecs[4] = '{3'd2, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 9};
        vecs[5] = '{3'd6, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1};
        vecs[6] = '{3'd3, 16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 9};
        vecs[7] = '{3'd0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 9};
        vecs[8] = '{3'd7, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1};

        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset alu outputs", 32'({bus.alu_valid_in, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_ctl}), 32'd0);
        check("reset rsp outputs", 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready after reset", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                            vecs[i].res, vecs[i].carry, vecs[i].zero, vecs[i].err, vecs[i].lat);
        end

        // First WAIT stalled for three cycles.
        stall_first_only = 1'b1;
        stall_amt        = 3;
        apply_and_check("stall", 3'd0, 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 12);
        stall_amt        = 0;
        stall_first_only = 1'b0;

        for (int i = 0; i < 30; i++) begin
            op  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            s   = $urandom_range(0, 2);
            stall_amt = s;
            r = ref_op(op, a, b, cin);
            apply_and_check($sformatf("rnd%0d", i), op, a, b, cin, r[W-1:0], r[W], r[W-1:0] == '0,
                            r[W+1], r[W+1] ? 1 : (2 * N + 1 + N * s));
        end
        stall_amt = 0;

        // Back-to-back with req_valid held high.
        bus.req_op    = 3'd0;
        bus.req_a     = 16'h0001;
        bus.req_b     = 16'h0002;
        bus.req_cin   = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_a  = 16'h0005;
        bus.req_b  = 16'h0006;
        first_rsp  = -1;
        second_rsp = -1;
        ready_edge = -1;
        n_rsp      = 0;
        res1       = '0;
        res2       = '0;
        for (int e = 1; e <= 40 && n_rsp < 2; e++) begin
            @(posedge clk); #1;
            if (bus.req_ready && ready_edge < 0) ready_edge = e;
            if (bus.rsp_valid) begin
                if (n_rsp == 0) begin first_rsp = e; res1 = bus.rsp_result; end
                else begin second_rsp = e; res2 = bus.rsp_result; end
                n_rsp++;
            end
        end
        bus.req_valid = 1'b0;
        check("b2b first rsp edge",  32'(first_rsp), 32'(2 * N));
        check("b2b ready edge",      32'(ready_edge), 32'(2 * N + 1));
        check("b2b second rsp edge", 32'(second_rsp), 32'(4 * N + 2));
        check("b2b first result",    32'(res1), 32'h0003);
        check("b2b second result",   32'(res2), 32'h000B);
        @(posedge clk); #1;

        // Reset after the second nibble capture.
        bus.req_op    = 3'd0;
        bus.req_a     = 16'h1111;
        bus.req_b     = 16'h2222;
        bus.req_cin   = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre-reset third issue", 32'(bus.alu_valid_in), 32'd1);
        reset = 1'b0;
        #1;
        check("mid reset alu outputs", 32'({bus.alu_valid_in, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_ctl}), 32'd0);
        check("mid reset rsp outputs", 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        rsp_seen = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) rsp_seen++;
        end
        check("no rsp after reset", 32'(rsp_seen), 32'd0);
        check("ready after mid reset", 32'(bus.req_ready), 32'd1);
        apply_and_check("post-reset", 3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_wide_seq.md
# alu_wide_seq

Multi-nibble sequencer that executes WIDTH = 4*NIBBLES-bit arithmetic/logic operations on the existing 4-bit registered ALU by issuing one nibble per ALU transaction and chaining carry/borrow through its own carry flag register. Sits between a requester (valid/ready request, one-cycle response pulse) and the ALU's input/output ports. It is the sole driver of the ALU inputs.

## Interface
- NIBBLES, default 4: operand width in nibbles (WIDTH = 4*NIBBLES, NIBBLES ≥ 1).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept when req_valid & req_ready.
- req_op  in  3  wide op: 0 W_ADD, 1 W_SUB, 2 W_AND, 3 W_OR, 4 W_XOR; 5-7 invalid.
- req_a, req_b  in  WIDTH  operands.
- req_cin  in  1  initial carry (W_ADD) / borrow (W_SUB); ignored for logic ops.
- rsp_valid  out  1  one-cycle pulse, response fields valid.
- rsp_result  out  WIDTH  result.
- rsp_carry  out  1  final carry/borrow (0 for logic ops and on error).
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  invalid req_op.
- alu_valid_in  out  1  ALU transaction strobe.
- alu_a, alu_b  out  4  operand nibbles.
- alu_cin  out  1  ALU carry input.
- alu_ctl  out  4  ALU opcode.
- alu_valid_out  in  1  ALU result valid.
- alu_result  in  4  ALU result nibble.
- alu_carry  in  1  ALU carry out.
- alu_zero  in  1  ignored (zero computed locally over full width).

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On accept: latch a, b, op; carry_r ← req_cin for ADD/SUB, 0 otherwise; nibble index k ← 0; valid op → ISSUE, invalid op → DONE with err flag set and result 0.
- ISSUE (one cycle): register alu_valid_in=1, alu_a=a[4k+3:4k], alu_b=b[4k+3:4k], alu_cin=carry_r, alu_ctl = ADD_c(4) for W_ADD, SUB_b(6) for W_SUB, AND(7), OR(8), XOR(9). → WAIT.
- WAIT: alu_valid_in=0. When alu_valid_out=1: result[4k+3:4k] ← alu_result, carry_r ← alu_carry; if k == NIBBLES-1 → DONE, else k++ → ISSUE. While alu_valid_out=0: stay in WAIT (stall, no timeout).
- DONE (one cycle): rsp_valid=1 with rsp_result, rsp_carry=carry_r (0 if err), rsp_zero, rsp_err; → IDLE.
- Logic ops still chain carry_r; ALU returns carry 0 for them, so rsp_carry = 0.
- Width rules: carry/borrow is bit 4 of the ALU's 5-bit result; W_SUB computes a - b - req_cin mod 2^WIDTH, rsp_carry = 1 on borrow.

## Timing
- Reset (async, any state): state IDLE; alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err all 0; req_ready=1 once reset deasserts. In-flight nibble results discarded, no response produced.
- All outputs except req_ready are registered; req_ready decodes state.
- Without stalls, with acceptance at edge T: rsp_valid high in cycle T+2*NIBBLES+1 (9 cycles for NIBBLES=4). Invalid op: rsp_valid in cycle T+1.
- Each ALU stall cycle in WAIT adds one cycle of latency.
- Back-to-back: req_ready returns high the cycle after DONE; minimum spacing between accepts is 2*NIBBLES+2 cycles.
- Request fields are ignored when not accepted. alu_valid_out outside WAIT is ignored.

## Structure
- Shared package alu_pkg: the ALU opcode_e enum (SEL…invalid_2), the wide-op enum wop_e (W_ADD…W_XOR), and the function mapping wop_e to opcode_e.
- No sub-module inside alu_wide_seq. A test-only wrapper alu_wide_sys instantiates alu_wide_seq and the ALU back to back.

## Test plan
- NIBBLES=4, W_ADD a=0xFFFF b=0x0001 cin=0 -> result 0x0000, carry 1, zero 1, err 0; ALU sees ctl=4 four times with cin 0,1,1,1; rsp_valid 9 cycles after accept.
- W_SUB a=0x0000 b=0x0001 cin=0 -> result 0xFFFF, carry 1, zero 0; ctl=6 on every issue. W_SUB a=0x1234 b=0x0234 cin=1 -> result 0x0FFF, carry 0.
- W_XOR a=0xA5A5 b=0x5A5A -> result 0xFFFF, carry 0, zero 0. W_AND a=0xF0F0 b=0x0F0F -> result 0x0000, zero 1.
- req_op=6 -> rsp_valid the cycle after accept with err 1, result 0, carry 0, and no alu_valid_in pulse. req_valid held high: second request accepted the cycle after DONE.
- Stall: force alu_valid_out low for 3 cycles in the first WAIT of W_ADD 0x0F0F+0x0101 -> rsp_valid 12 cycles after accept, result 0x1010, carry 0.
- Assert reset after the second nibble capture -> all outputs 0 immediately, no rsp_valid; after release req_ready=1, and a new W_ADD 0x0001+0x0001 returns 0x0002.
